ecc_scrubber: RTL and testbench

Background scrubber for a SECDED-protected memory holding 39-bit codewords ({ecc[6:0], data[31:0]}). It sits downstream of rvecc_encode/memory and feeds every read codeword into an internal rvecc_decode. It sweeps an address range, writes corrected words back on single-bit errors, counts singles and doubles, and latches the first double-error address for software.

---
 rtl/ecc_scrubber.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ecc_scrubber.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scrubber.sv
// Background SECDED scrubber: sweeps the memory, checks each 39-bit codeword,
// counts errors and (with ECC_SCRUB_WRITEBACK_EN defined) rewrites corrected singles.

module rvecc_decode (
  input  logic        en,
  input  logic [31:0] din,
  input  logic [6:0]  ecc_in,
  output logic [31:0] dout,
  output logic [6:0]  ecc_out,
  output logic        single_ecc_error,
  output logic        double_ecc_error
);

  // Data bits occupy the non-power-of-two Hamming positions 3..38; ecc[6] is overall parity.
  function automatic logic [6:0] ecc_gen(input logic [31:0] d);
    logic [5:0] syn;
    logic [4:0] k;
    syn = 6'd0;
    k   = 5'd0;
    for (int p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k]) syn = syn ^ p[5:0];
        k = k + 5'd1;
      end
    end
    return {(^d) ^ (^syn), syn};
  endfunction

  function automatic logic [31:0] flip_mask(input logic [5:0] s);
    logic [31:0] m;
    logic [4:0]  k;
    m = 32'd0;
    k = 5'd0;
    for (int p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        m[k] = (s == p[5:0]);
        k    = k + 5'd1;
      end
    end
    return m;
  endfunction

  logic [6:0] chk_s;
  logic [5:0] syn_s;
  logic       par_s;

  assign chk_s            = ecc_gen(din);
  assign syn_s            = ecc_in[5:0] ^ chk_s[5:0];
  assign par_s            = ^{ecc_in, din};
  assign single_ecc_error = en & par_s;
  assign double_ecc_error = en & ~par_s & (syn_s != 6'd0);
  assign dout             = single_ecc_error ? (din ^ flip_mask(syn_s)) : din;
  assign ecc_out          = ecc_gen(dout);

endmodule

module ecc_scrubber #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [38:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [38:0]       mem_rdata,
  output logic [CNT_W-1:0]  single_cnt,
  output logic [CNT_W-1:0]  double_cnt,
  output logic              double_seen,
  output logic [ADDR_W-1:0] first_double_addr
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    CHECK   = 3'd3,
    WR_REQ  = 3'd4,
    NEXT    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [38:0]       rdata_q, rdata_d;
  logic              stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0]  single_cnt_q, single_cnt_d;
  logic [CNT_W-1:0]  double_cnt_q, double_cnt_d;
  logic              double_seen_q, double_seen_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;

  logic [31:0] corr_data_s;
  logic [6:0]  corr_ecc_s;
  logic        single_err_s;
  logic        double_err_s;

  rvecc_decode u_dec (
    .en               (1'b1),
    .din              (rdata_q[31:0]),
    .ecc_in           (rdata_q[38:32]),
    .dout             (corr_data_s),
    .ecc_out          (corr_ecc_s),
    .single_ecc_error (single_err_s),
    .double_ecc_error (double_err_s)
  );

`ifdef ECC_SCRUB_WRITEBACK_EN
  logic [38:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
`else
  logic unused_corr_s;
  assign unused_corr_s = ^{corr_data_s, corr_ecc_s};
  assign mem_wdata     = 39'd0;
  assign mem_we        = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rdata_d       = rdata_q;
    stop_pend_d   = stop_pend_q;
    single_cnt_d  = single_cnt_q;
    double_cnt_d  = double_cnt_q;
    double_seen_d = double_seen_q;
    first_d       = first_q;
    done_d        = 1'b0;
`ifdef ECC_SCRUB_WRITEBACK_EN
    wdata_d       = wdata_q;
`endif
    if (state_q != IDLE && stop) stop_pend_d = 1'b1;
    else                         stop_pend_d = stop_pend_q;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          single_cnt_d  = {CNT_W{1'b0}};
          double_cnt_d  = {CNT_W{1'b0}};
          double_seen_d = 1'b0;
          first_d       = {ADDR_W{1'b0}};
          addr_d        = {ADDR_W{1'b0}};
          stop_pend_d   = 1'b0;
          state_d       = RD_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        if (mem_gnt) state_d = RD_WAIT;
        else         state_d = RD_REQ;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = CHECK;
        end else begin
          state_d = RD_WAIT;
        end
      end
      CHECK: begin
        if (single_err_s) begin
          if (single_cnt_q != {CNT_W{1'b1}}) single_cnt_d = single_cnt_q + CNT_W'(1);
          else                               single_cnt_d = single_cnt_q;
`ifdef ECC_SCRUB_WRITEBACK_EN
          wdata_d = {corr_ecc_s, corr_data_s};
          state_d = WR_REQ;
`else
          state_d = NEXT;
`endif
        end else if (double_err_s) begin
          if (double_cnt_q != {CNT_W{1'b1}}) double_cnt_d = double_cnt_q + CNT_W'(1);
          else                               double_cnt_d = double_cnt_q;
          if (!double_seen_q) begin
            first_d       = addr_q;
            double_seen_d = 1'b1;
          end else begin
            first_d = first_q;
          end
          state_d = NEXT;
        end else begin
          state_d = NEXT;
        end
      end
      WR_REQ: begin
        if (mem_gnt) state_d = NEXT;
        else         state_d = WR_REQ;
      end
      NEXT: begin
        // A stop arriving in this very cycle is honoured too, never a word later.
        if (addr_q == {ADDR_W{1'b1}} || stop_pend_q || stop) begin
          done_d      = 1'b1;
          stop_pend_d = 1'b0;
          state_d     = IDLE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    req_d   = (state_d == RD_REQ) || (state_d == WR_REQ);
    maddr_d = addr_d;
`ifdef ECC_SCRUB_WRITEBACK_EN
    we_d    = (state_d == WR_REQ);
`endif
  end

  // State, sweep bookkeeping and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= {ADDR_W{1'b0}};
      rdata_q       <= 39'd0;
      stop_pend_q   <= 1'b0;
      single_cnt_q  <= {CNT_W{1'b0}};
      double_cnt_q  <= {CNT_W{1'b0}};
      double_seen_q <= 1'b0;
      first_q       <= {ADDR_W{1'b0}};
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      req_q         <= 1'b0;
      maddr_q       <= {ADDR_W{1'b0}};
`ifdef ECC_SCRUB_WRITEBACK_EN
      wdata_q       <= 39'd0;
      we_q          <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rdata_q       <= rdata_d;
      stop_pend_q   <= stop_pend_d;
      single_cnt_q  <= single_cnt_d;
      double_cnt_q  <= double_cnt_d;
      double_seen_q <= double_seen_d;
      first_q       <= first_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      req_q         <= req_d;
      maddr_q       <= maddr_d;
`ifdef ECC_SCRUB_WRITEBACK_EN
      wdata_q       <= wdata_d;
      we_q          <= we_d;
`endif
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign mem_req           = req_q;
  assign mem_addr          = maddr_q;
  assign single_cnt        = single_cnt_q;
  assign double_cnt        = double_cnt_q;
  assign double_seen       = double_seen_q;
  assign first_double_addr = first_q;

endmodule

// File: tb/tb_ecc_scrubber.sv
// Bench for ecc_scrubber (ADDR_W=2, CNT_W=2): zero-wait memory model, expected
// transaction list derived from injected bit-flip counts, per-sweep result checks.

module tb_ecc_scrubber;

`ifdef ECC_SCRUB_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy, done, mem_req, mem_we;
  logic [1:0]  mem_addr;
  logic [38:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [38:0] mem_rdata = 39'd0;
  logic [1:0]  single_cnt, double_cnt;
  logic        double_seen;
  logic [1:0]  first_double_addr;

  ecc_scrubber #(.ADDR_W(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .single_cnt(single_cnt), .double_cnt(double_cnt), .double_seen(double_seen),
    .first_double_addr(first_double_addr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [38:0] golden [4];
  logic [38:0] mem    [4];
  int          stall_cnt = 0;
  bit          wr_block  = 1'b0;
  bit          rd_pend   = 1'b0;
  logic [38:0] rd_data   = 39'd0;

  bit          exp_we   [$];
  logic [1:0]  exp_addr [$];
  logic [38:0] exp_data [$];
  int          exp_single, exp_double, exp_first, exp_busy;
  bit          exp_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hamming position of data bit j: the j-th position from 3 upward that is not a power of two.
  function automatic int hpos(input int j);
    int n;
    n = -1;
    for (int p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        n++;
        if (n == j) return p;
      end
    end
    return 0;
  endfunction

  function automatic logic [6:0] model_ecc(input logic [31:0] d);
    logic [6:0] e;
    e = 7'd0;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 32; j++)
        if (((hpos(j) >> i) & 1) == 1) e[i] = e[i] ^ d[j];
    e[6] = (^d) ^ (^e[5:0]);
    return e;
  endfunction

  // Expected sweep outcome from the number of bits that differ from the golden word.
  task automatic build_expect(input int last);
    int ns, nd, flips;
    exp_we.delete(); exp_addr.delete(); exp_data.delete();
    ns = 0; nd = 0; exp_first = 0; exp_seen = 1'b0;
    for (int a = 0; a <= last; a++) begin
      exp_we.push_back(1'b0); exp_addr.push_back(2'(a)); exp_data.push_back(39'd0);
      flips = $countones(mem[a] ^ golden[a]);
      if (flips == 1) begin
        ns++;
        if (WB) begin
          exp_we.push_back(1'b1); exp_addr.push_back(2'(a)); exp_data.push_back(golden[a]);
        end
      end else if (flips == 2) begin
        nd++;
        if (!exp_seen) exp_first = a;
        exp_seen = 1'b1;
      end
    end
    exp_single = (ns > 3) ? 3 : ns;
    exp_double = (nd > 3) ? 3 : nd;
    exp_busy   = 4 * (last + 1) + (WB ? ns : 0);
  endtask

  // Memory model: grant decided mid-cycle, read data returned the following cycle.
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (rd_pend) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rd_data;
      rd_pend    = 1'b0;
    end
    mem_gnt = 1'b0;
    if (mem_req) begin
      if (stall_cnt > 0) stall_cnt--;
      else if (mem_we && !wr_block) begin
        mem_gnt = 1'b1;
        mem[mem_addr] = mem_wdata;
      end else if (!mem_we) begin
        mem_gnt = 1'b1;
        rd_pend = 1'b1;
        rd_data = mem[mem_addr];
      end
    end
  end

  bit         prev_held = 1'b0;
  logic [1:0] prev_addr = 2'd0;
  logic       prev_we   = 1'b0;

  // Single compare process: transactions against the expected list, stability, done results.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      prev_held = 1'b0;
    end else begin
      if (prev_held) check("req_stable", {mem_req, mem_we, mem_addr}, {1'b1, prev_we, prev_addr});
      if (!busy && mem_req) check("req_while_idle", mem_req, 1'b0);
      if (mem_req && mem_gnt) begin
        if (exp_we.size() == 0) begin
          check("unexpected_txn", {mem_we, mem_addr}, 3'b111);
        end else begin
          check("txn_we_addr", {mem_we, mem_addr}, {exp_we[0], exp_addr[0]});
          if (exp_we[0]) check("txn_wdata", mem_wdata, exp_data[0]);
          void'(exp_we.pop_front()); void'(exp_addr.pop_front()); void'(exp_data.pop_front());
        end
      end
      if (done) begin
        check("done_busy_low", busy, 1'b0);
        check("single_cnt", single_cnt, exp_single);
        check("double_cnt", double_cnt, exp_double);
        check("double_seen", double_seen, exp_seen);
        check("first_double_addr", first_double_addr, exp_first);
        check("txns_left", exp_we.size(), 0);
      end
      if (!WB) check("we_zero", {mem_we, mem_wdata}, 40'd0);
      prev_held = mem_req && !mem_gnt;
      prev_addr = mem_addr;
      prev_we   = mem_we;
    end
  end

  task automatic run_sweep(input string tag, input int busy_cycles, input int stop_addr);
    int  cyc, bcyc;
    bit  armed, stopping, fired;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #2;
    check({tag, "_busy_req_after_start"}, {busy, mem_req}, 2'b11);
    bcyc = 0; cyc = 0; armed = 1'b0; stopping = 1'b0; fired = 1'b0;
    while (!done && cyc < 400) begin
      if (busy) bcyc++;
      if (stopping) begin
        stop = 1'b0; stopping = 1'b0;
      end else if (armed) begin
        stop = 1'b1; stopping = 1'b1; armed = 1'b0;
      end
      if (stop_addr >= 0 && !fired && mem_req && !mem_we && mem_gnt && mem_addr == 2'(stop_addr)) begin
        armed = 1'b1; fired = 1'b1;
      end
      @(negedge clk); #2; cyc++;
    end
    stop = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done expected done within 400 cycles", tag);
    end
    check({tag, "_busy_cycles"}, bcyc, busy_cycles);
  endtask

  initial begin
    int cyc;
    for (int a = 0; a < 4; a++) begin
      logic [31:0] d;
      d = 32'h1357_9BDF ^ (32'h0101_0101 * a);
      golden[a] = {model_ecc(d), d};
      mem[a]    = golden[a];
    end
    check("model_ecc_0", model_ecc(32'h0000_0000), 7'h00);
    check("model_ecc_1", model_ecc(32'h0000_0001), 7'h43);
    check("model_ecc_2", model_ecc(32'h0000_0002), 7'h45);
    check("model_ecc_msb", model_ecc(32'h8000_0000), 7'h26);

    repeat (3) @(negedge clk);
    #2;
    check("reset_outputs", {busy, done, mem_req, mem_we, mem_addr, mem_wdata, single_cnt,
                            double_cnt, double_seen, first_double_addr}, 55'd0);
    rst = 1'b0;

    // Clean sweep, zero-wait memory.
    build_expect(3);
    run_sweep("clean", exp_busy, -1);
    check("clean_busy_16", exp_busy, 16);

    // Single error in word 2, data bit 5.
    mem[2] = golden[2] ^ (39'd1 << 5);
    build_expect(3);
    run_sweep("single", exp_busy, -1);
    check("single_mem_after", mem[2], WB ? golden[2] : (golden[2] ^ (39'd1 << 5)));

    // Double errors in words 1 and 3.
    for (int a = 0; a < 4; a++) mem[a] = golden[a];
    mem[1] = golden[1] ^ 39'h81;
    mem[3] = golden[3] ^ ((39'd1 << 33) | (39'd1 << 10));
    build_expect(3);
    run_sweep("double", exp_busy, -1);
    check("double_mem_untouched", mem[1], golden[1] ^ 39'h81);

    // Grant withheld 5 cycles on the first read.
    for (int a = 0; a < 4; a++) mem[a] = golden[a];
    build_expect(3);
    stall_cnt = 5;
    run_sweep("stall", exp_busy + 5, -1);

    // Stop during read-wait of word 1 (word 1 carries a single error).
    mem[1] = golden[1] ^ (39'd1 << 20);
    build_expect(1);
    run_sweep("stop", exp_busy, 1);

    // start and stop together in idle: ignored.
    mem[1] = golden[1];
    build_expect(-1);
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("start_stop_ignored", {busy, mem_req}, 2'b00);

    // All four words single: counter saturates at 3.
    for (int a = 0; a < 4; a++) mem[a] = golden[a] ^ (39'd1 << (a + 1));
    build_expect(3);
    run_sweep("saturate", exp_busy, -1);
    check("saturate_single_cnt", exp_single, 3);

    // Reset mid-sweep (during a stalled write-back, or a read without write-back).
    for (int a = 0; a < 4; a++) mem[a] = golden[a];
    mem[0] = golden[0] ^ (39'd1 << 12);
    build_expect(3);
    wr_block = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #2;
    cyc = 0;
    while (!(mem_req && (WB ? mem_we : (mem_addr == 2'd1))) && cyc < 100) begin
      @(negedge clk); #2; cyc++;
    end
    check("reset_trigger_seen", mem_req, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #2;
    check("midsweep_reset_outputs", {busy, done, mem_req, mem_we, mem_addr, mem_wdata, single_cnt,
                                     double_cnt, double_seen, first_double_addr}, 55'd0);
    rst = 1'b0; wr_block = 1'b0;
    build_expect(3);
    repeat (2) @(negedge clk);
    run_sweep("after_reset", exp_busy, -1);
    check("after_reset_mem0", mem[0], WB ? golden[0] : (golden[0] ^ (39'd1 << 12)));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
